// File: rtl/sram_sdp_fifo_pkg.sv
// Shared helpers for the sram_sdp_fifo slice.
//   log2b(value) : number of bits needed to represent 'value' (minimum 1),
//                  used to size RAM addresses and FIFO pointers.
//   QUEUE_DEPTH  : number of entries in the output queue that hides the
//                  RAM's read latency.
package sram_sdp_fifo_pkg;

  localparam int QUEUE_DEPTH = 2;

  function automatic int log2b(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/SRAM_SDP_Template.sv
// Simple dual-port RAM: one write port (a), one read port (b), one clock.
// Read data is registered, so doutb reflects addrb from the previous cycle.
// Ports:
//   clk   : clock
//   wea   : write enable for port a
//   addra : write address
//   dina  : write data
//   addrb : read address
//   doutb : registered read data
// The array is never reset; contents are only meaningful once written.
module SRAM_SDP_Template
  import sram_sdp_fifo_pkg::*;
#(
  parameter int RAM_WIDTH      = 128,
  parameter int RAM_DEPTH      = 256,
  parameter int RAM_ADDR_WIDTH = log2b(RAM_DEPTH - 1)
) (
  input  logic                      clk,
  input  logic                      wea,
  input  logic [RAM_ADDR_WIDTH-1:0] addra,
  input  logic [RAM_WIDTH-1:0]      dina,
  input  logic [RAM_ADDR_WIDTH-1:0] addrb,
  output logic [RAM_WIDTH-1:0]      doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wea) begin
      mem[addra] <= dina;
    end
    // Write-first bypass for a same-address collision.
    if (wea && (addra == addrb)) begin
      doutb <= dina;
    end else begin
      doutb <= mem[addrb];
    end
  end

endmodule

// File: rtl/sram_sdp_fifo.sv
// First-word-fall-through FIFO on a simple dual-port RAM.
// The RAM holds up to DEPTH entries; a 2-entry output queue in flops absorbs
// the RAM's 1-cycle read latency so one push and one pop can occur per cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : push request; accepted when wr_en && !full
//   wr_data  : push data
//   full     : RAM holds DEPTH entries (registered)
//   rd_en    : pop request; performed when rd_en && !empty
//   rd_data  : head entry, valid while empty == 0
//   empty    : output queue holds no entry (registered)
//   count    : total entries held = RAM entries + in-flight read + queue
//   wr_err   : 1-cycle pulse, cycle after a push attempted while full
//   rd_err   : 1-cycle pulse, cycle after a pop attempted while empty
// Handshake: wr_en is qualified by full and rd_en by empty, both sampled in
// the same cycle; a request against a blocked side is dropped, changes no
// state and raises the matching error pulse. Either request may be held high.
// Total capacity is DEPTH+2 because full only looks at the RAM.
module sram_sdp_fifo
  import sram_sdp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = log2b(DEPTH - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [1:0]            QUEUE_MAX = 2'(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [CNT_WIDTH-1:0]  ram_cnt;
  logic [CNT_WIDTH-1:0]  ram_cnt_nxt;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  rd_pend;
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic [2:0]            inflight;
  logic [DATA_WIDTH-1:0] q0;
  logic [DATA_WIDTH-1:0] q1;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  push;
  logic                  pop;
  logic                  issue;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // Entries that will sit in the queue or arrive into it next cycle. A new
  // read is only issued if its data is guaranteed a free slot on arrival.
  assign inflight = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue    = (ram_cnt != '0) && (inflight < 3'(QUEUE_DEPTH));

  // The RAM registers the read address internally, so the issue address is
  // presented combinationally; otherwise the last address is held.
  assign addrb = issue ? rd_ptr : addrb_q;

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (push && !issue) begin
      ram_cnt_nxt = ram_cnt + CNT_ONE;
    end else if (!push && issue) begin
      ram_cnt_nxt = ram_cnt - CNT_ONE;
    end
  end

  always_comb begin
    occ_nxt = occ;
    if (rd_pend && !pop) begin
      occ_nxt = occ + 2'd1;
    end else if (!rd_pend && pop) begin
      occ_nxt = occ - 2'd1;
    end
  end

  // rd_pend next equals issue.
  assign count_nxt = ram_cnt_nxt + CNT_WIDTH'(issue) + CNT_WIDTH'(occ_nxt);

  SRAM_SDP_Template #(
    .RAM_WIDTH      (DATA_WIDTH),
    .RAM_DEPTH      (DEPTH),
    .RAM_ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .wea   (push),
    .addra (wr_ptr),
    .dina  (wr_data),
    .addrb (addrb),
    .doutb (doutb)
  );

  // Pointers, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      addrb_q <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      occ     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      count   <= '0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_ONE;
      end
      if (issue) begin
        rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_ONE;
      end
      addrb_q <= addrb;
      ram_cnt <= ram_cnt_nxt;
      rd_pend <= issue;
      occ     <= occ_nxt;
      full    <= (ram_cnt_nxt == DEPTH_CNT);
      empty   <= (occ_nxt == 2'd0);
      count   <= count_nxt;
      wr_err  <= wr_en && full;
      rd_err  <= rd_en && empty;
    end
  end

  // Output queue: q0 is the head, q1 the second entry. A capture lands in the
  // first free slot after any same-cycle pop has shifted the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
    end else if (pop) begin
      if (occ == QUEUE_MAX) begin
        q0 <= q1;
        if (rd_pend) begin
          q1 <= doutb;
        end
      end else if (rd_pend) begin
        q0 <= doutb;
      end
    end else if (rd_pend) begin
      if (occ == 2'd0) begin
        q0 <= doutb;
      end else begin
        q1 <= doutb;
      end
    end
  end

  assign rd_data = q0;

`ifdef DEBUG_ON
  always @(posedge clk) begin
    if (!rst) begin
      assert (ram_cnt <= DEPTH_CNT);
      assert (occ <= QUEUE_MAX);
      assert (!(issue && (rd_ptr == wr_ptr) && (ram_cnt != DEPTH_CNT)));
    end
  end
`endif

endmodule

// File: tb/tb_sram_sdp_fifo.sv
// Directed and scoreboard bench for sram_sdp_fifo (DATA_WIDTH=128, DEPTH=256).
module tb_sram_sdp_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 256;
  localparam int CW    = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic          wr_err;
  logic          rd_err;
  logic [CW-1:0] count;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          exp_werr;
  logic          exp_rerr;

  sram_sdp_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count),
    .wr_err  (wr_err),
    .rd_err  (rd_err)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop everything the scoreboard still expects, with a cycle budget.
  task automatic drain(input string tag);
    int budget;
    budget = 2000;
    wr_en  = 1'b0;
    rd_en  = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (!empty) begin
        check(tag, rd_data, exp_q.pop_front());
      end
      step();
      budget--;
    end
    rd_en = 1'b0;
    check({tag, "_left"}, DW'(exp_q.size()), DW'(0));
    exp_q.delete();
    step();
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  initial begin
    // reset values
    rst = 1'b1;
    step();
    step();
    check("rst_full",   DW'(full),   DW'(0));
    check("rst_empty",  DW'(empty),  DW'(1));
    check("rst_count",  DW'(count),  DW'(0));
    check("rst_wr_err", DW'(wr_err), DW'(0));
    check("rst_rd_err", DW'(rd_err), DW'(0));
    check("rst_data",   rd_data,     DW'(0));
    rst = 1'b0;
    step();

    // single push: first-word latency of 3 cycles
    wr_en = 1'b1;
    wr_data = DW'(8'hA5);
    step();
    wr_en = 1'b0;
    check("t1_count", DW'(count), DW'(1));
    step();
    check("t1_empty_early", DW'(empty), DW'(1));
    step();
    check("t1_empty", DW'(empty), DW'(0));
    check("t1_data",  rd_data,    DW'(8'hA5));
    check("t1_count_head", DW'(count), DW'(1));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t1_empty_after", DW'(empty),  DW'(1));
    check("t1_count_after", DW'(count),  DW'(0));
    check("t1_rd_err",      DW'(rd_err), DW'(0));
    step();

    // fill: 258 pushes accepted (2 prefetched into the queue), then full
    for (int i = 0; i <= 258; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i);
      step();
      if (i == 256) begin
        check("t2_full_256",  DW'(full),  DW'(0));
        check("t2_count_256", DW'(count), DW'(257));
      end
      if (i == 257) begin
        check("t2_full",     DW'(full),   DW'(1));
        check("t2_count",    DW'(count),  DW'(258));
        check("t2_no_werr",  DW'(wr_err), DW'(0));
      end
      if (i == 258) begin
        check("t2_wr_err",     DW'(wr_err), DW'(1));
        check("t2_count_drop", DW'(count),  DW'(258));
        check("t2_full_hold",  DW'(full),   DW'(1));
      end
    end
    wr_en = 1'b0;
    step();
    check("t2_wr_err_end", DW'(wr_err), DW'(0));

    // drain with rd_en held: 258 pops in order, no bubbles
    rd_en = 1'b1;
    for (int i = 0; i < 258; i++) begin
      check("t3_empty", DW'(empty), DW'(0));
      check("t3_data",  rd_data,    DW'(i));
      step();
    end
    check("t3_empty_end", DW'(empty), DW'(1));
    check("t3_count_end", DW'(count), DW'(0));
    check("t3_full_end",  DW'(full),  DW'(0));
    check("t3_no_rderr",  DW'(rd_err), DW'(0));
    step();
    rd_en = 1'b0;
    check("t3_rd_err", DW'(rd_err), DW'(1));
    step();
    check("t3_rd_err_end", DW'(rd_err), DW'(0));

    // continuous push/pop with 5 entries resident: pointers wrap ~4 times
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(100 + i);
      exp_q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    step();
    step();
    step();
    check("t4_count_pre", DW'(count), DW'(5));
    for (int i = 0; i < 1000; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = DW'(1000 + i);
      check("t4_empty", DW'(empty), DW'(0));
      if (!empty) begin
        check("t4_data", rd_data, exp_q.pop_front());
      end
      if (!full) begin
        exp_q.push_back(wr_data);
      end
      step();
      check("t4_count", DW'(count), DW'(5));
    end
    drain("t4_drain");

    // random push/pop against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_werr = wr_en && full;
      exp_rerr = rd_en && empty;
      if (rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          check("t5_underflow", DW'(1), DW'(0));
        end else begin
          check("t5_data", rd_data, exp_q.pop_front());
        end
      end
      if (wr_en && !full) begin
        exp_q.push_back(wr_data);
      end
      step();
      check("t5_wr_err", DW'(wr_err), DW'(exp_werr));
      check("t5_rd_err", DW'(rd_err), DW'(exp_rerr));
      check("t5_count",  DW'(count),  DW'(exp_q.size()));
    end
    drain("t5_drain");

    // reset mid-operation with 100 entries, then no stale data
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(7 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    check("t6_count_pre", DW'(count), DW'(100));
    rst = 1'b1;
    #1;
    check("t6_empty", DW'(empty), DW'(1));
    check("t6_full",  DW'(full),  DW'(0));
    check("t6_count", DW'(count), DW'(0));
    check("t6_data",  rd_data,    DW'(0));
    step();
    rst = 1'b0;
    step();
    wr_en = 1'b1;
    wr_data = DW'(8'h3C);
    step();
    wr_en = 1'b0;
    step();
    step();
    check("t6_empty_post", DW'(empty), DW'(0));
    check("t6_data_post",  rd_data,    DW'(8'h3C));
    check("t6_count_post", DW'(count), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
